// File: rtl/modular_spi_master_pkg.sv
// Shared constants for the modular SPI master and its slave-side bench:
// FSM encoding, header field layout and frame length.
package modular_spi_master_pkg;

    localparam int unsigned ADDR_BITS_DEF  = 10;
    localparam int unsigned DATA_BITS_DEF  = 48;
    localparam int unsigned HDR_BITS_DEF   = 12;
    localparam int unsigned FRAME_BITS     = HDR_BITS_DEF + DATA_BITS_DEF;
    localparam int unsigned RW_BIT         = HDR_BITS_DEF - 1;
    localparam int unsigned ADDR_LSB       = 0;

    // Counters are sized for the largest supported frame, two edges per bit.
    localparam int unsigned MAX_FRAME_BITS = 511;
    localparam int unsigned EDGE_CNT_W     = $clog2(2 * MAX_FRAME_BITS + 1);
    localparam int unsigned TIMER_W        = 16;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StXfer  = 3'd2;
    localparam logic [2:0] StHold  = 3'd3;
    localparam logic [2:0] StLoad  = 3'd4;
    localparam logic [2:0] StGap   = 3'd5;

    function automatic int unsigned frame_len(input int unsigned hdr_bits,
                                              input int unsigned data_bits);
        return hdr_bits + data_bits;
    endfunction

endpackage

// File: rtl/modular_spi_master_clkgen.sv
// SCLK edge generator: HALF_DIV divider producing the bus clock and the
// per-edge sample/shift strobes for the selected SPI mode.
module modular_spi_clkgen #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic cpol_i,
    input  logic cpha_i,
    output logic sclk_o,
    output logic tick_o,
    output logic sample_o,
    output logic shift_o
);

    localparam int unsigned DivW = $clog2(HALF_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(HALF_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic            phase_q, phase_d;
    logic            lead, trail;

    // phase_q is the distance from idle level, so sclk resets straight to cpol.
    assign sclk_o = phase_q ^ cpol_i;
    assign tick_o = run_i && (div_q == DivLast);
    assign lead   = tick_o && !phase_q;
    assign trail  = tick_o && phase_q;

    assign sample_o = cpha_i ? trail : lead;
    assign shift_o  = cpha_i ? lead : trail;

    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        if (!run_i) begin
            div_d   = '0;
            phase_d = 1'b0;
        end else if (tick_o) begin
            div_d   = '0;
            phase_d = ~phase_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/modular_spi_master.sv
// Two-port round-robin SPI master issuing fixed-length header+data frames,
// with optional AWMF load strobe after write frames.
module modular_spi_master
    import modular_spi_master_pkg::*;
#(
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
    parameter int unsigned DATA_BITS = DATA_BITS_DEF,
    parameter int unsigned HDR_BITS  = HDR_BITS_DEF,
    parameter int unsigned HALF_DIV  = 4,
    parameter int unsigned GAP_CYC   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpol,
    input  logic                   cpha,
    input  logic                   mode_awmf,
    input  logic [1:0]             req,
    input  logic [1:0]             req_rw,
    input  logic [2*ADDR_BITS-1:0] req_addr,
    input  logic [2*DATA_BITS-1:0] req_wdata,
    output logic [1:0]             ack,
    output logic                   rsp_valid,
    output logic                   rsp_port,
    output logic [DATA_BITS-1:0]   rsp_rdata,
    output logic                   busy,
    output logic                   sclk,
    output logic                   cs_n,
    output logic                   mosi,
    input  logic                   miso,
    output logic                   ldb_n
);

    localparam int unsigned FRAME = frame_len(HDR_BITS, DATA_BITS);
    localparam logic [EDGE_CNT_W-1:0] LastEdge = EDGE_CNT_W'(2 * FRAME - 1);
    localparam logic [TIMER_W-1:0]    HalfLast = TIMER_W'(HALF_DIV - 1);
    localparam logic [TIMER_W-1:0]    GapLast  = TIMER_W'(GAP_CYC - 1);

    logic [2:0]            state_q, state_d;
    logic                  armed_q, armed_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [EDGE_CNT_W-1:0] edge_q, edge_d;
    logic [FRAME-1:0]      tx_q, tx_d;
    logic [DATA_BITS-1:0]  rx_q, rx_d;
    logic                  rw_q, rw_d;
    logic                  port_q, port_d;
    logic                  last_q, last_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_port_q, rsp_port_d;
    logic [DATA_BITS-1:0]  rsp_rdata_q, rsp_rdata_d;

    logic                  gnt_port;
    logic [ADDR_BITS-1:0]  sel_addr;
    logic [DATA_BITS-1:0]  sel_wdata;
    logic [FRAME-1:0]      frame;
    logic                  run, tick, sample, shift, shift_en;

    modular_spi_clkgen #(
        .HALF_DIV (HALF_DIV)
    ) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_i    (run),
        .cpol_i   (cpol),
        .cpha_i   (cpha),
        .sclk_o   (sclk),
        .tick_o   (tick),
        .sample_o (sample),
        .shift_o  (shift)
    );

    assign run = (state_q == StXfer);
    // With cpha=1 the first leading edge must not disturb the MSB set up in SETUP.
    assign shift_en = shift && !(cpha && (edge_q == '0));

    always_comb begin
        if (req == 2'b11) begin
            gnt_port = ~last_q;
        end else begin
            gnt_port = req[1];
        end
    end

    assign ack = (armed_q && (req != 2'b00)) ? (gnt_port ? 2'b10 : 2'b01) : 2'b00;

    assign sel_addr  = gnt_port ? req_addr[2*ADDR_BITS-1:ADDR_BITS] : req_addr[ADDR_BITS-1:0];
    assign sel_wdata = gnt_port ? req_wdata[2*DATA_BITS-1:DATA_BITS] : req_wdata[DATA_BITS-1:0];

    always_comb begin
        frame = '0;
        frame[FRAME-1] = req_rw[gnt_port];
        frame[DATA_BITS +: ADDR_BITS] = sel_addr;
        if (req_rw[gnt_port]) begin
            frame[DATA_BITS-1:0] = sel_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        edge_d      = edge_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rw_d        = rw_q;
        port_d      = port_q;
        last_d      = last_q;
        rsp_port_d  = rsp_port_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (ack != 2'b00) begin
                    state_d = StSetup;
                    timer_d = '0;
                    edge_d  = '0;
                    tx_d    = frame;
                    rx_d    = '0;
                    rw_d    = req_rw[gnt_port];
                    port_d  = gnt_port;
                    last_d  = gnt_port;
                end
            end
            StSetup: begin
                if (timer_q == HalfLast) begin
                    state_d = StXfer;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StXfer: begin
                if (shift_en) begin
                    tx_d = {tx_q[FRAME-2:0], 1'b0};
                end
                // The shift register keeps only the last DATA_BITS samples: the header falls off.
                if (sample) begin
                    rx_d = {rx_q[DATA_BITS-2:0], miso};
                end
                if (tick) begin
                    edge_d = edge_q + 1'b1;
                    if (edge_q == LastEdge) begin
                        state_d = StHold;
                        timer_d = '0;
                    end
                end
            end
            StHold: begin
                if (timer_q == HalfLast) begin
                    timer_d = '0;
                    state_d = (rw_q && mode_awmf) ? StLoad : StGap;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StLoad: begin
                if (timer_q == HalfLast) begin
                    timer_d = '0;
                    state_d = StGap;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StGap: begin
                if (timer_q == GapLast) begin
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase

        rsp_valid_d = (state_d == StGap) && (state_q != StGap);
        if (rsp_valid_d) begin
            rsp_port_d  = port_q;
            rsp_rdata_d = rw_q ? '0 : rx_q;
        end
        armed_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            armed_q     <= 1'b0;
            timer_q     <= '0;
            edge_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rw_q        <= 1'b0;
            port_q      <= 1'b0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            timer_q     <= timer_d;
            edge_q      <= edge_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rw_q        <= rw_d;
            port_q      <= port_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign cs_n      = !((state_q == StSetup) || (state_q == StXfer) || (state_q == StHold));
    assign mosi      = cs_n ? 1'b0 : tx_q[FRAME-1];
    assign ldb_n     = (state_q != StLoad);
    assign rsp_valid = rsp_valid_q;
    assign rsp_port  = rsp_port_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_modular_spi_master.sv
// Randomized scoreboard bench for modular_spi_master with a behavioural
// register-file SPI slave and a reference memory model.
module tb_modular_spi_master;
    import modular_spi_master_pkg::*;

    localparam int AW   = 10;
    localparam int DW   = 48;
    localparam int HW   = 12;
    localparam int FW   = FRAME_BITS;
    localparam int HALF = 4;
    localparam int GAP  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpol, cpha, mode_awmf;
    logic [1:0]    req, req_rw, ack;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic          rsp_valid, rsp_port, busy, sclk, cs_n, mosi, ldb_n;
    logic          miso = 1'b0;
    logic [DW-1:0] rsp_rdata;

    typedef struct {
        int            port;
        logic [DW-1:0] rdata;
        int            ldb;
    } exp_t;

    exp_t          exp_q[$];
    logic [FW-1:0] frame_q[$];
    logic [DW-1:0] ref_mem[int];
    logic [DW-1:0] slv_mem[int];
    int            n_checks = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    modular_spi_master #(
        .ADDR_BITS (AW),
        .DATA_BITS (DW),
        .HDR_BITS  (HW),
        .HALF_DIV  (HALF),
        .GAP_CYC   (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpol      (cpol),
        .cpha      (cpha),
        .mode_awmf (mode_awmf),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_port  (rsp_port),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .ldb_n     (ldb_n)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Request on port p; on grant, record the expected frame and response.
    task automatic issue(input int p, input bit rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        int            n = 0;
        logic [FW-1:0] f;
        exp_t          e;
        @(posedge clk);
        #1;
        req_rw[p] = rw;
        req_addr[p*AW +: AW] = a;
        req_wdata[p*DW +: DW] = d;
        req[p] = 1'b1;
        @(negedge clk);
        while (!ack[p] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!ack[p]) begin
            n_checks++;
            $display("FAIL ack_timeout port %0d: got no ack, expected ack", p);
            req[p] = 1'b0;
            return;
        end
        f = '0;
        f[FW-1] = rw;
        f[DW +: AW] = a;
        if (rw) f[DW-1:0] = d;
        frame_q.push_back(f);
        e.port = p;
        e.ldb  = (rw && mode_awmf) ? HALF : 0;
        if (rw) begin
            e.rdata = '0;
            ref_mem[int'(a)] = d;
        end else begin
            e.rdata = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req[p] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0 || frame_q.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            n_checks++;
            $display("FAIL idle_timeout: got busy=%0d pending=%0d, expected idle", busy,
                     exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: arbitration, ack/busy exclusion, gap length, ldb pulse and responses.
    int   rr_last = 1;
    int   ldb_cnt = 0;
    int   cs_hi = 0;
    bit   seen_frame = 1'b0;
    logic prev_cs = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            rr_last    = 1;
            ldb_cnt    = 0;
            cs_hi      = 0;
            seen_frame = 1'b0;
            prev_cs    = 1'b1;
        end else begin
            if (ack != 2'b00) begin
                chk("ack_while_busy", busy, 0);
                chk("sclk_idle_at_ack", sclk, cpol);
                chk("ack_onehot", (ack == 2'b01) || (ack == 2'b10), 1);
                if (req == 2'b11) chk("rr_grant", ack, (rr_last != 0) ? 2'b01 : 2'b10);
                rr_last = ack[1] ? 1 : 0;
            end
            if (!ldb_n) begin
                ldb_cnt++;
                chk("ldb_cs_high", cs_n, 1);
            end
            if (cs_n) begin
                cs_hi++;
            end else if (prev_cs) begin
                if (seen_frame) chk("gap_min_len", cs_hi >= GAP, 1);
                seen_frame = 1'b1;
                cs_hi = 0;
            end
            prev_cs = cs_n;
            if (rsp_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_rsp: got rsp_valid port %0d, expected none",
                             rsp_port);
                end else begin
                    exp_t e;
                    n_pass++;
                    e = exp_q.pop_front();
                    chk("rsp_port", rsp_port, e.port);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("ldb_low_cycles", ldb_cnt, e.ldb);
                    chk("sclk_idle_after", sclk, cpol);
                end
                ldb_cnt = 0;
            end
        end
    end

    // Behavioural slave: register file addressed by the header, MSB-first.
    bit            s_act = 1'b0;
    int            s_cnt, s_rise;
    logic [FW-1:0] s_rx;
    logic [DW-1:0] s_tx;
    logic          s_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            s_act = 1'b0;
            miso  = 1'b0;
            frame_q.delete();
        end else if (!cs_n) begin
            if (!s_act) begin
                s_act  = 1'b1;
                s_cnt  = 0;
                s_rise = 0;
                s_rx   = '0;
                miso   = 1'b0;
            end else if (sclk !== s_prev) begin
                if (sclk) s_rise++;
                if ((s_prev == cpol) != cpha) begin
                    s_rx = {s_rx[FW-2:0], mosi};
                    s_cnt++;
                    if (s_cnt == HW)
                        s_tx = slv_mem.exists(int'(s_rx[AW-1:0])) ? slv_mem[int'(s_rx[AW-1:0])] : '0;
                    if (s_cnt >= HW && s_cnt < FW) miso = s_tx[DW-1-(s_cnt-HW)];
                end
            end
        end else if (s_act) begin
            s_act = 1'b0;
            miso  = 1'b0;
            chk("sclk_rising_edges", s_rise, FW);
            if (frame_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame: got 0x%0h, expected none", s_rx);
            end else begin
                chk("mosi_frame", s_rx, frame_q.pop_front());
            end
            if (s_cnt == FW && s_rx[FW-1]) slv_mem[int'(s_rx[DW +: AW])] = s_rx[DW-1:0];
        end
        s_prev = sclk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpol = 1'b0; cpha = 1'b0; mode_awmf = 1'b0;
        req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_ldb_n", ldb_n, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_port", rsp_port, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        req = 2'b11;
        #1;
        chk("rst_ack", ack, 0);
        req = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Mode 0 write then read-back on port 0.
        issue(0, 1'b1, 10'h155, 48'hA5A5_1234_5678);
        wait_idle();
        issue(0, 1'b0, 10'h155, '0);
        wait_idle();

        // Simultaneous requests right after reset.
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            fork
                issue(0, 1'b1, AW'(10'h0A0 + i), {16'hC0DE, $urandom});
                issue(1, 1'b0, 10'h155, '0);
            join
            wait_idle();
        end

        // Modes 1..3 at the top address.
        for (int m = 1; m < 4; m++) begin
            cpol = m[1];
            cpha = m[0];
            #1;
            chk("sclk_idle_mode", sclk, cpol);
            issue(m & 1, 1'b1, 10'h3FF, 48'hFFFF_0000_FFFF);
            wait_idle();
            issue(m & 1, 1'b0, 10'h3FF, '0);
            wait_idle();
        end

        // AWMF write followed by a read.
        cpol = 1'b0; cpha = 1'b0; mode_awmf = 1'b1;
        issue(0, 1'b1, 10'h001, 48'h1);
        wait_idle();
        issue(1, 1'b0, 10'h001, '0);
        wait_idle();
        mode_awmf = 1'b0;

        // Reset in the middle of a read frame.
        cpol = 1'b1; cpha = 1'b1;
        issue(1, 1'b0, 10'h155, '0);
        begin
            int   e = 0;
            int   n = 0;
            logic ps = sclk;
            while (e < 30 && n < 5000) begin
                @(negedge clk);
                if (sclk !== ps) e++;
                ps = sclk;
                n++;
            end
            chk("edge30_reached", e, 30);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, cpol);
        chk("abort_busy", busy, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_rdata", rsp_rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_cs_n", cs_n, 1);
        chk("release_sclk", sclk, cpol);
        chk("release_busy", busy, 0);
        repeat (20) @(negedge clk);
        issue(0, 1'b0, 10'h155, '0);
        wait_idle();

        // Randomized traffic over a small address pool.
        for (int i = 0; i < 24; i++) begin
            logic [AW-1:0] a0, a1;
            if (i % 4 == 0) begin
                cpol = 1'($urandom_range(0, 1));
                cpha = 1'($urandom_range(0, 1));
                mode_awmf = 1'($urandom_range(0, 1));
            end
            a0 = AW'($urandom_range(0, 7) * 37);
            a1 = AW'($urandom_range(0, 7) * 37);
            if ($urandom_range(0, 2) == 0) begin
                fork
                    issue(0, 1'($urandom_range(0, 1)), a0, {16'($urandom), $urandom});
                    issue(1, 1'($urandom_range(0, 1)), a1, {16'($urandom), $urandom});
                join
            end else begin
                issue($urandom_range(0, 1), 1'($urandom_range(0, 1)), a0,
                      {16'($urandom), $urandom});
            end
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/modular_spi_master.md
MODULAR_SPI_MASTER -- requirements
Module: modular_spi_master

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, register address width.
REQ-002 SHALL have parameter DATA_BITS, default 48, data field width.
REQ-003 SHALL have parameter HDR_BITS, default 12, header width; frame = HDR_BITS+DATA_BITS (60).
REQ-004 SHALL have parameter HALF_DIV, default 4, SCLK half-period in clk cycles; legal range 4..255.
REQ-005 SHALL have parameter GAP_CYC, default 8, minimum cs_n-high idle between frames in clk cycles.
REQ-006 Ports SHALL be:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- cpol, cpha  in  1 each  SPI mode; static while busy.
- mode_awmf  in  1  1 = AWMF chain mode; write frames end with an ldb_n pulse.
- req  in  2  per-port transaction request; level, held until ack.
- req_rw  in  2  per port; 1 = write, 0 = read.
- req_addr  in  2xADDR_BITS  per-port address.
- req_wdata  in  2xDATA_BITS  per-port write data.
- ack  out  2  one-cycle grant pulse; the port's fields are captured this cycle.
- rsp_valid  out  1  one-cycle frame-complete pulse.
- rsp_port  out  1  port index of the completed frame.
- rsp_rdata  out  DATA_BITS  read data; zero for writes.
- busy  out  1  high from ack until return to IDLE.
- sclk, cs_n, mosi  out  1 each  SPI bus.
- miso  in  1  SPI read data.
- ldb_n  out  1  AWMF load strobe.

Function
REQ-007 Frame SHALL be MSB-first: header bit HDR_BITS-1 = rw, bits ADDR_BITS-1..0 = addr, other header bits 0, then DATA_BITS of data (wdata for writes, 0 for reads).
REQ-008 Arbitration SHALL be round-robin in IDLE: if both ports request, grant the port not granted last; after reset, port 0 wins a tie.
REQ-009 FSM states SHALL be IDLE, SETUP, XFER, HOLD, LOAD, GAP.
REQ-010 IDLE→SETUP SHALL occur on the ack cycle. SETUP drives cs_n=0 and mosi=frame MSB and lasts HALF_DIV cycles.
REQ-011 XFER SHALL toggle sclk every HALF_DIV cycles from idle level cpol, for exactly 2×frame edges, then return sclk to cpol.
REQ-012 For cpha=0, mosi SHALL update on each trailing edge. For cpha=1, mosi SHALL update on each leading edge. The first bit is presented per REQ-010.
REQ-013 miso SHALL be sampled at the sample edge (leading for cpha=0, trailing for cpha=1). Samples 13..60 SHALL shift MSB-first into rdata; samples 1..12 are discarded.
REQ-014 HOLD SHALL keep cs_n=0 for HALF_DIV cycles after the last edge, then drive cs_n=1.
REQ-015 LOAD SHALL be entered only for a write with mode_awmf=1. It pulses ldb_n=0 for HALF_DIV cycles, then ldb_n=1; otherwise HOLD goes directly to GAP.
REQ-016 rsp_valid SHALL pulse on the first GAP cycle, with rsp_port and rsp_rdata stable until the next rsp_valid.
REQ-017 GAP SHALL last GAP_CYC cycles with cs_n=1, then return to IDLE. No ack is issued before IDLE.
REQ-018 Edge and bit counters SHALL be sized for frame ≤ 511 bits and SHALL NOT wrap within a frame.
REQ-019 Changes to req while busy SHALL be ignored; a request deasserted before ack is dropped silently.

Reset
REQ-020 On rst_n low, the block SHALL asynchronously force: state IDLE, sclk=cpol, cs_n=1, ldb_n=1, mosi=0, ack=0, rsp_valid=0, rsp_port=0, rsp_rdata=0, busy=0, round-robin pointer=port 1 (so port 0 wins next).
REQ-021 Reset mid-frame SHALL abort the frame with no rsp_valid. The bus SHALL be idle on the first cycle after release.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding, the header field positions (RW bit index, ADDR_BITS), and the frame-length constant, for reuse by the slave bench.
REQ-023 The SCLK edge generator (HALF_DIV counter, leading/trailing/sample/shift strobes from cpol/cpha) SHALL be one sub-module, modular_spi_clkgen; arbitration and the shift datapath stay in the top.

Verification
REQ-024 Port 0 writes addr 0x155, data 0xA5A5_1234_5678, mode 0 (cpol=0, cpha=0), awmf=0; then reads it back. Required: slave returns rsp_rdata = 0xA5A5_1234_5678, and exactly 60 rising sclk edges occur per frame.
REQ-025 Both ports request simultaneously 3 times after reset. Required: ack order is 0,1,0, and rsp_port matches the ack order.
REQ-026 For each of modes 1/2/3, write then read addr 0x3FF with data 0xFFFF_0000_FFFF. Required: data matches, and sclk idles at cpol between frames.
REQ-027 AWMF write with mode_awmf=1, addr 0x001, data 0x1. Required: ldb_n is low for 4 cycles after cs_n rises, and a subsequent read returns 0x1.
REQ-028 Assert rst_n low at edge 30 of a frame. Required: cs_n=1 and sclk=cpol immediately, no rsp_valid, and the next frame completes correctly.
REQ-029 Measure idle between back-to-back frames. Required: cs_n-high interval ≥ GAP_CYC cycles, and ack never asserts while busy=1.
